uart_fifo_sync: RTL
===================

# uart_fifo_sync

Parametrised synchronous FIFO for the UART datapath, placed between the UART RX deserialiser and the command decoder, and between the command encoder and the UART TX serialiser. It generalises the team's fixed 8x8 register file into a full FIFO with configurable width and depth. It owns read/write pointers, full/empty/almost-full status, a fill count and a registered read port with a valid strobe. Optional sticky overflow/underflow error flags can be compiled in.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 3, address width; depth = 2**ADDR_W (legal range 1..8)
- AFULL_TH, 6, oAFull asserts when count >= AFULL_TH (legal range 1..2**ADDR_W)
- iClk  in  1  system clock; all logic is on the rising edge
- iRst  in  1  reset; synchronous, active-high
- iWr  in  1  write request
- iWrData  in  DATA_W  write data
- iRd  in  1  read request
- oRdData  out  DATA_W  read data, registered
- oRdValid  out  1  one-cycle strobe; oRdData is valid this cycle
- oFull  out  1  FIFO holds 2**ADDR_W words
- oAFull  out  1  count >= AFULL_TH
- oEmpty  out  1  FIFO holds 0 words
- oCount  out  ADDR_W+1  current fill level, 0..2**ADDR_W
- iClrErr  in  1  clears sticky error flags (present only with FIFO_ERR_FLAG_EN)
- oOvf  out  1  sticky overflow flag (present only with FIFO_ERR_FLAG_EN)
- oUdf  out  1  sticky underflow flag (present only with FIFO_ERR_FLAG_EN)

## Operation
- Pointers: rWrPtr and rRdPtr are ADDR_W+1 bits wide. The low ADDR_W bits address memory. The MSB is the wrap bit.
- Empty: rWrPtr == rRdPtr.
- Full: the MSBs differ and the low bits are equal.
- Count: rWrPtr - rRdPtr, modulo 2**(ADDR_W+1).
- Write accept (wAcc): iWr && !oFull. The word is stored at rWrPtr[ADDR_W-1:0] and rWrPtr increments.
- Read accept (rAcc): iRd && !oEmpty. The word at rRdPtr[ADDR_W-1:0] is loaded into oRdData, oRdValid is set for one cycle, and rRdPtr increments.
- Rejected write: the write is dropped. Memory and pointers are unchanged.
- Rejected read: oRdValid stays 0 and oRdData holds its value.
- Simultaneous iWr and iRd:
  - Neither full nor empty: both are accepted and count is unchanged.
  - Full: the read is accepted and the write is rejected. There is no pass-through.
  - Empty: the write is accepted and the read is rejected. There is no bypass.
- oRdData holds the last read word until the next accepted read. It is never tri-stated.
- Pointers wrap naturally at 2**(ADDR_W+1). No special-case logic is needed at the wrap.
- Reset: both pointers go to 0, oRdData to 0, oRdValid to 0 and error flags to 0. Memory contents are not reset and are treated as undefined.
- Reset mid-operation: any in-flight read strobe is cancelled. The FIFO is empty the cycle after iRst is sampled high.

## Timing
- Write to visibility: a word written at edge N raises count and clears oEmpty after edge N. It is readable by a request in cycle N+1.
- Read latency: 1 cycle. iRd accepted at edge N gives oRdData and oRdValid valid after edge N, for one cycle.
- Status outputs (oFull, oEmpty, oAFull, oCount) are combinational decodes of registered pointers. They are glitch-free relative to iClk and update the cycle after the accepting edge.
- Reset values:
  - oEmpty = 1
  - oFull = 0
  - oAFull = 0
  - oCount = 0
  - oRdValid = 0
  - oRdData = 0
  - oOvf = 0
  - oUdf = 0
- Throughput: one write and one read per cycle.

## Configuration
- Macro: FIFO_ERR_FLAG_EN.
- Defined:
  - oOvf sets on iWr && oFull. oUdf sets on iRd && oEmpty.
  - Both flags hold until iClrErr or iRst.
  - If a set event and iClrErr occur in the same cycle, the set wins.
- Undefined: iClrErr, oOvf and oUdf are not present on the port list. All other behaviour is identical.

## Structure
- Shared package fifo_pkg:
  - Default constants DATA_W_DEF = 8 and ADDR_W_DEF = 3.
  - Count-width rule: ADDR_W+1.
- Sub-module fifo_mem: simple dual-port register array, 2**ADDR_W x DATA_W.
  - Synchronous write on iWr.
  - Registered read on iRd.
  - No reset on the array.
- The top level holds the pointers, status decode and error flags.

## Test plan
All scenarios use DATA_W=8, ADDR_W=3, AFULL_TH=6.
- Reset then idle: hold iRst 1 for 2 cycles -> oEmpty=1, oCount=0, oRdValid=0, oRdData=8'h00.
- Fill and drain: write 8'h10..8'h17 -> oAFull rises after the 6th write and oFull after the 8th. A 9th write of 8'hFF is dropped (oOvf=1 with the macro). Then 8 reads -> oRdData 8'h10..8'h17 in order, each one cycle after iRd, and oEmpty=1 after the last.
- Wrap-around: 3 rounds of writing 5 words and reading 5 words -> data stays in order across the pointer wrap, and oCount returns to 0 after each round.
- Simultaneous at full: with 8 words held, assert iWr (8'hAA) and iRd together -> the read is accepted, the write is rejected and oCount=7. 8'hAA never appears on oRdData.
- Simultaneous at empty: assert iWr (8'h5C) and iRd together on an empty FIFO -> oRdValid=0 and oCount=1. The next iRd returns 8'h5C.
- Mid-operation reset and errors: with 4 words held, pulse iRst -> oEmpty=1 the next cycle, and a following iRd sets oUdf. iClrErr clears oUdf. The same-cycle set-and-clear case leaves oUdf=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the UART datapath FIFO.
package fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 3;

  // Pointers and fill count carry one extra wrap bit above the memory address.
  function automatic int unsigned cnt_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array with synchronous write and registered read.
// The array itself has no reset; only the read register is cleared.
module fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iWr,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iRd,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rd_data_q;

  // Store the incoming word when the write is accepted.
  always_ff @(posedge iClk) begin
    if (iWr) begin
      mem_q[iWrAddr] <= iWrData;
    end
  end

  // Load the read register on an accepted read; it holds otherwise.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      rd_data_q <= '0;
    end else if (iRd) begin
      rd_data_q <= mem_q[iRdAddr];
    end
  end

  assign oRdData = rd_data_q;

endmodule

// File: rtl/uart_fifo_sync.sv
// Parametrised synchronous FIFO for the UART RX/TX datapath.
// Owns pointers, status decode and (with FIFO_ERR_FLAG_EN defined) sticky
// overflow/underflow flags with a clear input.
module uart_fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned AFULL_TH = 6
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iWr,
  input  logic [DATA_W-1:0]          iWrData,
  input  logic                       iRd,
  output logic [DATA_W-1:0]          oRdData,
  output logic                       oRdValid,
  output logic                       oFull,
  output logic                       oAFull,
  output logic                       oEmpty,
  output logic [cnt_w(ADDR_W)-1:0]   oCount
`ifdef FIFO_ERR_FLAG_EN
  ,
  input  logic                       iClrErr,
  output logic                       oOvf,
  output logic                       oUdf
`endif
);

  localparam int unsigned PtrW = cnt_w(ADDR_W);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            rd_valid_q, rd_valid_d;
  logic [PtrW-1:0] count;
  logic            w_acc, r_acc;

  // Status is decoded from registered pointers only, so it cannot glitch mid-cycle.
  always_comb begin
    count  = wr_ptr_q - rd_ptr_q;
    oEmpty = (wr_ptr_q == rd_ptr_q);
    oFull  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
             (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    oAFull = (count >= PtrW'(AFULL_TH));
    oCount = count;
  end

  // Accept decode and pointer/strobe next state; no full-to-empty pass-through.
  always_comb begin
    w_acc      = iWr && !oFull;
    r_acc      = iRd && !oEmpty;
    wr_ptr_d   = w_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = r_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_valid_d = r_acc;
  end

  // Pointer and read-strobe registers; reset cancels any in-flight strobe.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign oRdValid = rd_valid_q;

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .iClk    (iClk),
    .iRst    (iRst),
    .iWr     (w_acc),
    .iWrAddr (wr_ptr_q[ADDR_W-1:0]),
    .iWrData (iWrData),
    .iRd     (r_acc),
    .iRdAddr (rd_ptr_q[ADDR_W-1:0]),
    .oRdData (oRdData)
  );

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags; a set event in the same cycle as a clear wins.
  always_comb begin
    ovf_d = iClrErr ? 1'b0 : ovf_q;
    udf_d = iClrErr ? 1'b0 : udf_q;
    if (iWr && oFull) begin
      ovf_d = 1'b1;
    end
    if (iRd && oEmpty) begin
      udf_d = 1'b1;
    end
  end

  // Error flag registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign oOvf = ovf_q;
  assign oUdf = udf_q;
`endif

endmodule
